// File: rtl/wsp_driver.sv
`default_nettype none
// ============================================================================
// Module      : wsp_driver
// Description : Wrapper Serial Port initiator for an IEEE 1500 wrapper.
//               Takes one scan command (register select, length, data),
//               sequences setup, capture, shift and update on the WSP
//               strobes, and returns the bits collected from wso.
// Revision    : 1.0 - initial release
// ============================================================================
module wsp_driver #(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_wir,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               select_wir,
    output logic               capture_wr,
    output logic               shift_wr,
    output logic               update_wr,
    output logic               wsi,
    input  logic               wso
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_CAPTURE = 3'd2,
        S_SHIFT   = 3'd3,
        S_UPDATE  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_t               state;
    // Remaining shift cycles minus one once shifting; full length before.
    logic [LEN_W-1:0]     cnt;
    // Shift-in data, consumed LSB first.
    logic [MAX_LEN-1:0]   data_sr;
    // One-hot pointer to the rsp_data bit written on the current shift cycle.
    logic [MAX_LEN-1:0]   bit_mask;
    logic [LEN_W-1:0]     len_clamped;
    logic                 accept;

    // Oversized lengths saturate at the chain capacity; handshake decode.
    always_comb begin
        len_clamped = (cmd_len > MAX_LEN_L) ? MAX_LEN_L : cmd_len;
        accept      = cmd_valid & cmd_ready;
    end

    // Command sequencer; every WSP output is a register so strobes never glitch.
    always_ff @(posedge clk) begin
        if (arst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            data_sr    <= '0;
            bit_mask   <= '0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            select_wir <= 1'b0;
            capture_wr <= 1'b0;
            shift_wr   <= 1'b0;
            update_wr  <= 1'b0;
            wsi        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state      <= S_SETUP;
                        cmd_ready  <= 1'b0;
                        select_wir <= cmd_wir;
                        data_sr    <= cmd_data;
                        cnt        <= len_clamped;
                        // Previous response is held until here, then cleared
                        // so bits beyond the new length read back as zero.
                        rsp_data   <= '0;
                    end
                end

                S_SETUP: begin
                    state      <= S_CAPTURE;
                    capture_wr <= 1'b1;
                end

                S_CAPTURE: begin
                    capture_wr <= 1'b0;
                    if (cnt == '0) begin
                        // Zero-length command: capture straight into update.
                        state     <= S_UPDATE;
                        update_wr <= 1'b1;
                    end else begin
                        state    <= S_SHIFT;
                        shift_wr <= 1'b1;
                        wsi      <= data_sr[0];
                        data_sr  <= data_sr >> 1;
                        cnt      <= cnt - LEN_W'(1);
                        bit_mask <= MAX_LEN'(1);
                    end
                end

                S_SHIFT: begin
                    // The chain output present during this cycle lands in
                    // the response bit for this cycle's index.
                    rsp_data <= rsp_data | (wso ? bit_mask : '0);
                    bit_mask <= bit_mask << 1;
                    if (cnt == '0) begin
                        state     <= S_UPDATE;
                        shift_wr  <= 1'b0;
                        wsi       <= 1'b0;
                        update_wr <= 1'b1;
                    end else begin
                        cnt     <= cnt - LEN_W'(1);
                        wsi     <= data_sr[0];
                        data_sr <= data_sr >> 1;
                    end
                end

                S_UPDATE: begin
                    state      <= S_DONE;
                    update_wr  <= 1'b0;
                    select_wir <= 1'b0;
                    rsp_valid  <= 1'b1;
                end

                S_DONE: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                end

                default: begin
                    state      <= S_IDLE;
                    cmd_ready  <= 1'b1;
                    rsp_valid  <= 1'b0;
                    select_wir <= 1'b0;
                    capture_wr <= 1'b0;
                    shift_wr   <= 1'b0;
                    update_wr  <= 1'b0;
                    wsi        <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wsp_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_wsp_driver
// Description : Scoreboard bench for wsp_driver. A behavioural wrapper chain
//               answers the WSP strobes; expected responses come from a
//               bit-stream model (captured cells followed by shifted data).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wsp_driver;

    localparam int MAX_LEN = 64;
    localparam int LEN_W   = 7;

    logic               clk = 1'b0;
    logic               arst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_wir;
    logic [LEN_W-1:0]   cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic               select_wir;
    logic               capture_wr;
    logic               shift_wr;
    logic               update_wr;
    logic               wsi;
    logic               wso;

    wsp_driver #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .arst       (arst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_wir    (cmd_wir),
        .cmd_len    (cmd_len),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .select_wir (select_wir),
        .capture_wr (capture_wr),
        .shift_wr   (shift_wr),
        .update_wr  (update_wr),
        .wsi        (wsi),
        .wso        (wso)
    );

    always #5 clk = ~clk;

    int vec_cnt  = 0;
    int fail_cnt = 0;
    int cyc      = 0;

    // Cycle index; read at negedges so it names the cycle being observed.
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          t;
        int          n;
        int          L;
        bit          wir;
        bit          chk_chain;
        logic [63:0] data;
        logic [63:0] exp_rsp;
        logic [63:0] exp_chain;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mask_of(input int n);
        return (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
    endfunction

    // Behavioural wrapper chain: cell 0 drives wso, wsi enters the top cell.
    int          chain_len = 8;
    logic [63:0] cfi_val   = '0;
    logic [63:0] chain     = '0;
    logic [63:0] upd_reg   = '0;
    bit          tie_one   = 1'b0;

    always @(posedge clk) begin
        if (capture_wr) chain <= cfi_val;
        else if (shift_wr) begin
            chain <= chain >> 1;
            chain[chain_len-1] <= wsi;
        end
        if (update_wr) upd_reg <= chain;
    end

    assign wso = tie_one ? 1'b1 : chain[0];

    // Reference: the chain emits its captured cells, then the shifted-in data.
    function automatic void model(input int L, input logic [63:0] c, input logic [63:0] d,
                                  input int n, input bit tie,
                                  output logic [63:0] rsp, output logic [63:0] ch);
        logic [127:0] seq;
        seq = '0;
        for (int i = 0; i < 128; i++) begin
            if (i < L) seq[i] = c[i];
            else if (i - L < 64) seq[i] = d[i-L];
        end
        rsp = '0;
        ch  = '0;
        for (int k = 0; k < n; k++) rsp[k] = tie ? 1'b1 : seq[k];
        for (int j = 0; j < L; j++) ch[j] = seq[n+j];
    endfunction

    // Monitor state accumulated between responses.
    int          cap_cyc, upd_cyc, shift_cnt, sel_cnt, sel_first, viol;
    int          upd_total = 0;
    logic [63:0] wsi_seq;

    task automatic clear_mon();
        cap_cyc = -1; upd_cyc = -1; shift_cnt = 0; sel_cnt = 0;
        sel_first = -1; viol = 0; wsi_seq = '0;
    endtask

    initial clear_mon();

    // Monitor: records strobe activity and checks it against the scoreboard on rsp_valid.
    always @(negedge clk) begin
        if (arst) clear_mon();
        else begin
            if ((int'(capture_wr) + int'(shift_wr) + int'(update_wr)) > 1) viol++;
            if (!shift_wr && wsi) viol++;
            if (cmd_ready && (capture_wr || shift_wr || update_wr || select_wir || rsp_valid)) viol++;
            if (capture_wr) cap_cyc = cyc;
            if (update_wr) begin upd_cyc = cyc; upd_total++; end
            if (shift_wr) begin
                if (shift_cnt < 64) wsi_seq[shift_cnt] = wsi;
                shift_cnt++;
            end
            if (select_wir) begin
                if (sel_cnt == 0) sel_first = cyc;
                sel_cnt++;
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_data", rsp_data, e.exp_rsp);
                    chk("rsp_cycle", cyc, e.t + 4 + e.n);
                    chk("capture_cycle", cap_cyc, e.t + 2);
                    chk("update_cycle", upd_cyc, e.t + 3 + e.n);
                    chk("shift_count", shift_cnt, e.n);
                    chk("wsi_sequence", wsi_seq, e.data & mask_of(e.n));
                    chk("select_count", sel_cnt, e.wir ? e.n + 3 : 0);
                    if (e.wir) chk("select_first", sel_first, e.t + 1);
                    chk("strobe_violations", viol, 0);
                    if (e.chk_chain) chk("chain_after_update", upd_reg & mask_of(e.L), e.exp_chain);
                end
                clear_mon();
            end
        end
    end

    // Present a command, wait for acceptance and push the expected response.
    task automatic issue(input bit wir, input int raw, input logic [63:0] d, input int L,
                         input logic [63:0] c, input bit tie, input bit keep, output int t);
        exp_t e;
        int   w;
        @(negedge clk);
        chain_len = L;
        cfi_val   = c & mask_of(L);
        tie_one   = tie;
        cmd_wir   = wir;
        cmd_len   = LEN_W'(raw);
        cmd_data  = d;
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 200) begin @(negedge clk); w++; end
        if (!cmd_ready) begin
            chk("accept_timeout", cmd_ready, 1);
            cmd_valid = 1'b0;
            t = -1;
            return;
        end
        t = cyc;
        e.t = t;
        e.n = (raw > MAX_LEN) ? MAX_LEN : raw;
        e.L = L;
        e.wir = wir;
        e.chk_chain = !tie;
        e.data = d;
        model(L, c & mask_of(L), d, e.n, tie, e.exp_rsp, e.exp_chain);
        exp_q.push_back(e);
        if (!keep) begin @(negedge clk); cmd_valid = 1'b0; end
    endtask

    task automatic wait_done();
        int w = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && w < 400) begin @(negedge clk); w++; end
        chk("completion_timeout", (exp_q.size() == 0 && cmd_ready), 1);
    endtask

    int exp_updates = 0;

    // Watchdog against a hung handshake.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Directed scenarios followed by randomized commands.
    initial begin
        int t, t1, t2, ub;
        arst = 1'b1; cmd_valid = 1'b0; cmd_wir = 1'b0; cmd_len = '0; cmd_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {cmd_ready, rsp_valid, select_wir, capture_wr, shift_wr, update_wr, wsi}, 7'b1000000);
        chk("reset_rsp_data", rsp_data, 0);
        arst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", cmd_ready, 1);

        // WDR loop: 8 cells capture A5, shift in 3C.
        issue(1'b0, 8, 64'h3C, 8, 64'hA5, 1'b0, 1'b0, t);
        wait_done(); exp_updates++;
        chk("wdr_rsp_a5", rsp_data, 64'hA5);
        chk("wdr_chain_3c", upd_reg & 64'hFF, 64'h3C);

        // WIR select with data 101.
        issue(1'b1, 3, 64'h5, 3, 64'h2, 1'b0, 1'b0, t);
        wait_done(); exp_updates++;

        // Zero length.
        issue(1'b0, 0, 64'hFFFF, 5, 64'h1B, 1'b0, 1'b0, t);
        wait_done(); exp_updates++;
        chk("len0_rsp_zero", rsp_data, 0);

        // Clamp with wso tied high, second command held valid during the first.
        issue(1'b0, 70, {$urandom, $urandom}, 4, 64'h0, 1'b1, 1'b1, t1);
        issue(1'b1, 5, 64'h1F, 4, 64'h0, 1'b1, 1'b0, t2);
        chk("b2b_accept_cycle", t2, t1 + 69);
        wait_done(); exp_updates += 2;
        chk("post_b2b_rsp", rsp_data, 64'h1F);

        // Reset in the middle of a len=8 shift.
        ub = upd_total;
        issue(1'b1, 8, {$urandom, $urandom}, 8, 64'h5A, 1'b0, 1'b0, t);
        while (cyc < t + 5) @(negedge clk);
        arst = 1'b1;
        @(negedge clk);
        chk("midop_reset_ctrl", {cmd_ready, rsp_valid, select_wir, capture_wr, shift_wr, update_wr, wsi}, 7'b1000000);
        chk("midop_reset_rsp", rsp_data, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        arst = 1'b0;
        repeat (12) @(negedge clk);
        chk("midop_ready", cmd_ready, 1);
        chk("midop_no_update", upd_total, ub);

        // Randomized commands through the chain model.
        for (int i = 0; i < 25; i++) begin
            int L;
            L = int'($urandom_range(1, 16));
            issue(1'($urandom % 2), int'($urandom_range(0, MAX_LEN + 6)), {$urandom, $urandom},
                  L, {$urandom, $urandom}, 1'b0, 1'b0, t);
            wait_done(); exp_updates++;
        end

        chk("total_update_pulses", upd_total, exp_updates);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wsp_driver.md
# wsp_driver

Wrapper Serial Port (WSP) initiator for the IEEE 1500 wrapper. It accepts one scan command at a time: register select, shift length and shift-in data. It then sequences the WSP control signals that the boundary cells and the WIR respond to, in the order setup, capture, shift, update. It returns the bits collected on the serial return path. It sits between the on-chip test controller and the wrapper chain.

## Interface
- MAX_LEN, default 64: maximum shift length in bits.
- LEN_W, default $clog2(MAX_LEN+1): width of the length field.

- clk  in  1  system/wrapper clock; all logic is on its rising edge.
- arst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  driver idle and able to accept a command.
- cmd_wir  in  1  1 = target WIR path, 0 = target the selected WDR/WBR path.
- cmd_len  in  LEN_W  number of shift cycles; values above MAX_LEN clamp to MAX_LEN.
- cmd_data  in  MAX_LEN  serial data to shift in, LSB first.
- rsp_valid  out  1  one-cycle pulse: operation complete.
- rsp_data  out  MAX_LEN  bits collected from wso. Bit i is the bit seen on shift cycle i. Held until the next accept.
- select_wir  out  1  WSP SelectWIR.
- capture_wr  out  1  WSP CaptureWR, drives cell capture.
- shift_wr  out  1  WSP ShiftWR, drives cell shift.
- update_wr  out  1  WSP UpdateWR, drives cell update.
- wsi  out  1  serial data to chain input (cti of first cell).
- wso  in  1  serial data from chain output (cto of last cell).

## Operation
- FSM states: IDLE, SETUP, CAPTURE, SHIFT, UPDATE, DONE.
- **IDLE:** cmd_ready=1; all WSP outputs 0. On cmd_valid&cmd_ready, latch cmd_wir, the clamped length and cmd_data, then go to SETUP.
- **SETUP (1 cycle):** select_wir=latched cmd_wir; no other strobe.
- **CAPTURE (1 cycle):** capture_wr=1.
- **SHIFT (len cycles):**
  - shift_wr=1 and wsi=data[k] on shift cycle k (k=0..len-1).
  - At the closing edge of cycle k, register wso into rsp_data[k].
  - Down-counter reaches 0 → UPDATE.
- **UPDATE (1 cycle):** update_wr=1.
- **DONE (1 cycle):** rsp_valid=1, then return to IDLE.
- **select_wir stability:** holds the latched value from SETUP through UPDATE inclusive. It is forced to 0 in IDLE and DONE.
- **Strobe exclusivity:** capture_wr, shift_wr and update_wr are mutually exclusive and never asserted together in any cycle.
- **len=0:** CAPTURE goes directly to UPDATE. No shift_wr pulse; rsp_data all 0.
- **rsp_data width:** bits at index ≥ len are 0.
- **Command acceptance:** cmd_valid while busy is ignored (cmd_ready=0). The command is not queued.
- **wsi outside SHIFT:** driven 0.

## Timing
- **Reset values:** cmd_ready=1 (after reset release), rsp_valid=0, rsp_data=0, select_wir=0, capture_wr=0, shift_wr=0, update_wr=0, wsi=0. State=IDLE.
- **Sequence:** accept edge at cycle t (cycle t itself is IDLE).
  - SETUP at t+1.
  - CAPTURE at t+2.
  - SHIFT at t+3 … t+2+len.
  - UPDATE at t+3+len.
  - DONE (rsp_valid) at t+4+len.
  - cmd_ready=1 again at t+5+len.
- **Back-to-back:** minimum command-to-command spacing is len+5 cycles.
- **Registered outputs:** all WSP outputs are registered; each strobe is high for exactly the cycles stated, with no glitch cycles.
- **Reset mid-operation:** at the next edge with arst=1 all outputs go to reset values and the FSM returns to IDLE. No update_wr is issued and the partial rsp_data is discarded (zeroed). If arst is high on the accept edge, the command is not accepted.
- **Clamp:** cmd_len=MAX_LEN+k shifts exactly MAX_LEN cycles.

## Test plan
- **Reset:** hold arst 3 cycles mid-SHIFT of a len=8 op → all outputs reset values next edge, cmd_ready=1, no update_wr pulse ever seen.
- **WDR loop:**
  - Setup: chain of 8 wc_sf1_cii cells; cells preloaded via capture with cfi=8'hA5; cmd_wir=0, len=8, data=8'h3C.
  - Response: rsp_data=8'hA5; chain holds 8'h3C after UPDATE.
  - Strobes: shift_wr high for exactly 8 cycles; rsp_valid at t+12.
- **WIR select:** cmd_wir=1, len=3, data=3'b101 → select_wir=1 from t+1 to t+6 inclusive, 0 at t+7 (DONE); wsi sequence 1,0,1.
- **len=0:** capture_wr at t+2, update_wr at t+3, rsp_valid at t+4, rsp_data=0, shift_wr never high.
- **Clamp/back-to-back:**
  - MAX_LEN=64, cmd_len=70, wso tied 1 → 64 shift cycles, rsp_data all ones.
  - Second command held valid throughout is accepted only at t+69.
  - Strobes are never simultaneous.
